postadder: RTL and testbench

POSTADDER -- requirements
Module: postadder

---
 rtl/postadder_pkg.sv | 41 ++++
 rtl/postadder_poly_adder.sv | 34 +++
 rtl/postadder.sv | 179 +++++++++++++++++
 tb/tb_postadder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/postadder_pkg.sv
// Shared types for the post-multiplier combiner: redundant L3 polynomial,
// mode encodings, result-select tags and coefficient-wise add/sub helpers.
package PARAMS_BN254_d0;

  localparam int NUM_COEF    = 4;
  localparam int COEF_W      = 16;
  localparam int NUM_THREADS = 4;

  typedef logic [COEF_W-1:0] coef_t;
  typedef coef_t [NUM_COEF-1:0] redundant_poly_L3;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_KARA = 2'b01,
    MODE_PAIR = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_PASS = 2'd0,
    SEL_ADD  = 2'd1,
    SEL_SUB0 = 2'd2,
    SEL_SUB1 = 2'd3
  } sel_e;

  // Coefficients wrap independently; the redundant form is never reduced here.
  function automatic redundant_poly_L3 poly_add(input redundant_poly_L3 a,
                                                input redundant_poly_L3 b);
    redundant_poly_L3 r;
    for (int i = 0; i < NUM_COEF; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  function automatic redundant_poly_L3 poly_sub(input redundant_poly_L3 a,
                                                input redundant_poly_L3 b);
    redundant_poly_L3 r;
    for (int i = 0; i < NUM_COEF; i++) r[i] = a[i] - b[i];
    return r;
  endfunction

endpackage

// File: rtl/postadder_poly_adder.sv
// Coefficient-wise redundant L3 adder/subtractor (z = a +/- b), LATENCY register
// stages, always accepts; no backpressure.
module poly_adder_L3_L3
  import PARAMS_BN254_d0::*;
#(
  parameter int LATENCY  = 1,
  parameter bit SUBTRACT = 1'b0
) (
  input  logic             clk,
  input  redundant_poly_L3 a,
  input  redundant_poly_L3 b,
  output redundant_poly_L3 z
);

  redundant_poly_L3 res_d;

  always_comb begin
    res_d = SUBTRACT ? poly_sub(a, b) : poly_add(a, b);
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign z = res_d;
    end else begin : g_pipe
      redundant_poly_L3 pipe_q [LATENCY];
      always_ff @(posedge clk) begin
        pipe_q[0] <= res_d;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign z = pipe_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/postadder.sv
// Per-thread Karatsuba/pairwise combiner for multiplier products; every result
// appears exactly 2 cycles after its beat; accepts a beat every cycle, no backpressure.
module postadder
  import PARAMS_BN254_d0::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_in,
  input  logic [1:0]       thread,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  redundant_poly_L3 P,
  output logic             valid_out,
  output logic [1:0]       thread_out,
  output redundant_poly_L3 Z,
  output logic             seq_err
);

  redundant_poly_L3 s0_q [NUM_THREADS];
  redundant_poly_L3 s0_d [NUM_THREADS];
  redundant_poly_L3 s1_q [NUM_THREADS];
  redundant_poly_L3 s1_d [NUM_THREADS];
  logic [1:0]       cnt_q [NUM_THREADS];
  logic [1:0]       cnt_d [NUM_THREADS];
  mode_e            lmode_q [NUM_THREADS];
  mode_e            lmode_d [NUM_THREADS];

  mode_e            mode_n;
  logic [1:0]       cur_cnt;
  logic             emit;
  logic             err;
  sel_e             sel;

  logic             v1_q, err1_q;
  logic [1:0]       thr1_q;
  sel_e             sel1_q;
  redundant_poly_L3 p1_q;

  logic             valid_out_q, valid_out_d;
  logic [1:0]       thread_out_q, thread_out_d;
  logic             seq_err_q, seq_err_d;
  redundant_poly_L3 z_q, z_d;

  redundant_poly_L3 s0_rd, s1_rd, add_z, sub0_z, sub1_z;

  assign s0_rd = s0_q[thread];
  assign s1_rd = s1_q[thread];

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    emit    = 1'b0;
    err     = 1'b0;
    sel     = SEL_PASS;
    cur_cnt = cnt_q[thread];
    case (mode)
      2'b01:   mode_n = MODE_KARA;
      2'b10:   mode_n = MODE_PAIR;
      default: mode_n = MODE_PASS;
    endcase

    if (valid_in) begin
      lmode_d[thread] = mode_n;
      // A mode switch mid-sequence abandons the partial result and restarts.
      if (cur_cnt != 2'd0 && mode_n != lmode_q[thread]) begin
        err            = 1'b1;
        cur_cnt        = 2'd0;
        cnt_d[thread]  = 2'd0;
      end
      case (mode_n)
        MODE_KARA: begin
          case (cur_cnt)
            2'd0: begin
              s0_d[thread]  = P;
              cnt_d[thread] = 2'd1;
            end
            2'd1: begin
              s1_d[thread]  = poly_add(s0_q[thread], P);
              cnt_d[thread] = 2'd2;
              emit          = 1'b1;
              sel           = SEL_SUB0;
            end
            default: begin
              cnt_d[thread] = 2'd0;
              emit          = 1'b1;
              sel           = SEL_SUB1;
            end
          endcase
        end
        MODE_PAIR: begin
          if (cur_cnt == 2'd0) begin
            s0_d[thread]  = P;
            cnt_d[thread] = 2'd1;
          end else begin
            cnt_d[thread] = 2'd0;
            emit          = 1'b1;
            sel           = SEL_ADD;
          end
        end
        default: begin
          emit = 1'b1;
          sel  = SEL_PASS;
        end
      endcase
    end

    if (clear) begin
      for (int t = 0; t < NUM_THREADS; t++) cnt_d[t] = 2'd0;
    end
  end

  poly_adder_L3_L3 #(.LATENCY(1), .SUBTRACT(1'b0)) u_add (
    .clk (clk), .a (s0_rd), .b (P),     .z (add_z)
  );
  poly_adder_L3_L3 #(.LATENCY(1), .SUBTRACT(1'b1)) u_sub0 (
    .clk (clk), .a (s0_rd), .b (P),     .z (sub0_z)
  );
  poly_adder_L3_L3 #(.LATENCY(1), .SUBTRACT(1'b1)) u_sub1 (
    .clk (clk), .a (P),     .b (s1_rd), .z (sub1_z)
  );

  always_comb begin
    valid_out_d  = v1_q;
    thread_out_d = thr1_q;
    seq_err_d    = err1_q;
    z_d          = '0;
    if (v1_q) begin
      case (sel1_q)
        SEL_ADD:  z_d = add_z;
        SEL_SUB0: z_d = sub0_z;
        SEL_SUB1: z_d = sub1_z;
        default:  z_d = p1_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t]   <= 2'd0;
        lmode_q[t] <= MODE_PASS;
      end
      v1_q         <= 1'b0;
      err1_q       <= 1'b0;
      thr1_q       <= 2'd0;
      sel1_q       <= SEL_PASS;
      valid_out_q  <= 1'b0;
      thread_out_q <= 2'd0;
      seq_err_q    <= 1'b0;
      z_q          <= '0;
    end else begin
      cnt_q        <= cnt_d;
      lmode_q      <= lmode_d;
      v1_q         <= valid_in & emit;
      err1_q       <= err;
      thr1_q       <= thread;
      sel1_q       <= sel;
      valid_out_q  <= valid_out_d;
      thread_out_q <= thread_out_d;
      seq_err_q    <= seq_err_d;
      z_q          <= z_d;
    end
  end

  // Operand storage and the pass-through copy carry no reset.
  always_ff @(posedge clk) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
    p1_q <= P;
  end

  assign valid_out  = valid_out_q;
  assign thread_out = thread_out_q;
  assign seq_err    = seq_err_q;
  assign Z          = z_q;

endmodule

// File: tb/tb_postadder.sv
// Directed bench for postadder: hand-computed vectors, outputs sampled on the falling edge.
module tb_postadder;
  import PARAMS_BN254_d0::*;

  localparam int PW = $bits(redundant_poly_L3);

  logic             clk = 1'b0;
  logic             rstn;
  logic             valid_in;
  logic [1:0]       thread;
  logic [1:0]       mode;
  logic             clear;
  redundant_poly_L3 P;
  logic             valid_out;
  logic [1:0]       thread_out;
  redundant_poly_L3 Z;
  logic             seq_err;

  int n_cmp = 0;
  int n_bad = 0;

  postadder dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .thread     (thread),
    .mode       (mode),
    .clear      (clear),
    .P          (P),
    .valid_out  (valid_out),
    .thread_out (thread_out),
    .Z          (Z),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  function automatic redundant_poly_L3 fill(input int v);
    redundant_poly_L3 r;
    for (int i = 0; i < NUM_COEF; i++) r[i] = coef_t'(v);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] thr, input logic [1:0] md, input int pv);
    valid_in = v;
    thread   = thr;
    mode     = md;
    P        = fill(pv);
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 2'b00, 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input int thr, input int zv);
    check_eq({tag, "_vld"}, PW'(valid_out), PW'(1));
    check_eq({tag, "_thr"}, PW'(thread_out), PW'(thr));
    check_eq({tag, "_z"}, Z, fill(zv));
  endtask

  int c0_tab [4] = '{45, 54, 63, 72};
  int c1_tab [4] = '{245, 235, 225, 215};

  initial begin
    rstn  = 1'b0;
    clear = 1'b0;
    idle();
    #2;
    check_eq("rst_vld", PW'(valid_out), PW'(0));
    check_eq("rst_thr", PW'(thread_out), PW'(0));
    check_eq("rst_z", Z, '0);
    check_eq("rst_err", PW'(seq_err), PW'(0));
    step();
    step();
    rstn = 1'b1;
    step();

    // Pass on thread 2
    drive(1'b1, 2'd2, 2'b00, 7);
    step();
    check_eq("pass_early", PW'(valid_out), PW'(0));
    idle();
    step();
    check_out("pass", 2, 7);
    step();
    check_eq("pass_after", PW'(valid_out), PW'(0));

    // Karatsuba on thread 1: 10, 3, 20 -> c0 = 7, c1 = 20 - 13 = 7
    drive(1'b1, 2'd1, 2'b01, 10);
    step();
    check_eq("kara_t0", PW'(valid_out), PW'(0));
    drive(1'b1, 2'd1, 2'b01, 3);
    step();
    check_eq("kara_t0b", PW'(valid_out), PW'(0));
    drive(1'b1, 2'd1, 2'b01, 20);
    step();
    check_out("kara_c0", 1, 7);
    idle();
    step();
    check_out("kara_c1", 1, 7);
    step();
    check_eq("kara_after", PW'(valid_out), PW'(0));

    // Round-robin Karatsuba: thread t gets 50+10t, 5+t, 300+t
    for (int i = 0; i < 13; i++) begin
      int t;
      int j;
      t = i % 4;
      if (i < 4)       drive(1'b1, 2'(t), 2'b01, 50 + 10 * t);
      else if (i < 8)  drive(1'b1, 2'(t), 2'b01, 5 + t);
      else if (i < 12) drive(1'b1, 2'(t), 2'b01, 300 + t);
      else             idle();
      step();
      j = i - 1;
      if (j >= 4)
        check_out($sformatf("ilv%0d", j), j % 4, (j < 8) ? c0_tab[j % 4] : c1_tab[j % 4]);
      else if (j >= 0)
        check_eq($sformatf("ilv%0d_vld", j), PW'(valid_out), PW'(0));
    end

    // Pairwise add on thread 3: 4 + 9 = 13
    drive(1'b1, 2'd3, 2'b10, 4);
    step();
    check_eq("pair_a", PW'(valid_out), PW'(0));
    drive(1'b1, 2'd3, 2'b10, 9);
    step();
    check_eq("pair_b", PW'(valid_out), PW'(0));
    idle();
    step();
    check_out("pair", 3, 13);

    // Thread 0: KARA beat, then PAIR breaks the sequence, next PAIR completes 6 + 8
    drive(1'b1, 2'd0, 2'b01, 11);
    step();
    drive(1'b1, 2'd0, 2'b10, 6);
    step();
    check_eq("serr_pre", PW'(seq_err), PW'(0));
    drive(1'b1, 2'd0, 2'b10, 8);
    step();
    check_eq("serr_pulse", PW'(seq_err), PW'(1));
    check_eq("serr_novld", PW'(valid_out), PW'(0));
    idle();
    step();
    check_out("serr_pair", 0, 14);
    check_eq("serr_gone", PW'(seq_err), PW'(0));

    // Clear mid-sequence: thread 1 restarts, 30 then 5 -> c0 = 25
    drive(1'b1, 2'd1, 2'b01, 10);
    step();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b1, 2'd1, 2'b01, 30);
    step();
    drive(1'b1, 2'd1, 2'b01, 5);
    step();
    check_eq("clr_restart", PW'(valid_out), PW'(0));
    idle();
    step();
    check_out("clr_c0", 1, 25);

    // Reset while a result is on the outputs and thread 2 is mid-sequence
    drive(1'b1, 2'd2, 2'b01, 40);
    step();
    drive(1'b1, 2'd2, 2'b01, 15);
    step();
    idle();
    step();
    check_out("prerst", 2, 25);
    rstn = 1'b0;
    #1;
    check_eq("midrst_vld", PW'(valid_out), PW'(0));
    check_eq("midrst_z", Z, '0);
    step();
    rstn = 1'b1;
    drive(1'b1, 2'd2, 2'b01, 7);
    step();
    drive(1'b1, 2'd2, 2'b01, 3);
    step();
    check_eq("postrst_t0", PW'(valid_out), PW'(0));
    idle();
    step();
    check_out("postrst_c0", 2, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
